// File: rtl/ppe_pkg.sv
// Shared packet layout, opcodes, router addresses and FSM encoding for the
// PPE input stage.
package ppe_pkg;

    localparam int PKT_W       = 33;
    localparam int DEST_HI     = 32;
    localparam int DEST_LO     = 29;
    localparam int OP_HI       = 28;
    localparam int OP_LO       = 25;
    localparam int DATA_HI     = 24;
    localparam int DATA_LO     = 0;

    localparam int IFMAP_SIZE  = 25;
    localparam int FILTER_SIZE = 5;
    localparam int OUTPUT_SIZE = 21;

    localparam logic [3:0] IMEM_ID          = 4'd11;
    localparam logic [3:0] OP_WEIGHTS_DONE  = 4'd0;
    localparam logic [3:0] OP_PPE_INPUT     = 4'd1;
    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

    typedef struct packed {
        logic [DEST_HI-DEST_LO:0] dest;
        logic [OP_HI-OP_LO:0]     opcode;
        logic [DATA_HI:DATA_LO]   data;
    } pkt_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        STREAM     = 2'd2,
        STALL      = 2'd3
    } state_e;

endpackage

// File: rtl/ppe_row_dbuf.sv
// Active/shadow row double buffer with the sliding-window mux.
// Swap has priority; a bypass swap loads the active row straight from the packet.
module ppe_row_dbuf
    import ppe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   load_active_i,
    input  logic                   load_shadow_i,
    input  logic                   swap_i,
    input  logic                   swap_bypass_i,
    input  logic [IFMAP_SIZE-1:0]  data_i,
    input  logic [4:0]             col_i,
    output logic                   shadow_full_o,
    output logic [FILTER_SIZE-1:0] win_data_o
);

    logic [IFMAP_SIZE-1:0] active_q;
    logic [IFMAP_SIZE-1:0] shadow_q;
    logic                  shadow_full_q;

    // Buffer registers and shadow occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= 25'd0;
            shadow_q      <= 25'd0;
            shadow_full_q <= 1'b0;
        end else if (clear_i) begin
            active_q      <= 25'd0;
            shadow_q      <= 25'd0;
            shadow_full_q <= 1'b0;
        end else if (swap_i) begin
            active_q      <= swap_bypass_i ? data_i : shadow_q;
            shadow_full_q <= 1'b0;
        end else if (load_active_i) begin
            active_q      <= data_i;
        end else if (load_shadow_i) begin
            shadow_q      <= data_i;
            shadow_full_q <= 1'b1;
        end
    end

    assign shadow_full_o = shadow_full_q;
    assign win_data_o    = active_q[col_i +: FILTER_SIZE];

endmodule

// File: rtl/ppe_row_feeder.sv
// PPE input stage: accepts ifmap row packets, streams 21 windows per row and
// prefetches the next row from IFMAP memory while the current one streams.
module ppe_row_feeder
    import ppe_pkg::*;
#(
    parameter int PE_ID = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [32:0] pkt_in,
    input  logic        pkt_in_valid,
    output logic        pkt_in_ready,
    output logic [32:0] req_pkt,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [4:0]  win_data,
    output logic [4:0]  win_col,
    output logic [4:0]  win_row,
    output logic        win_valid,
    input  logic        win_ready,
    output logic        row_done,
    output logic        ts_done,
    output logic        pkt_drop
);

    localparam logic [3:0] PE_ADDR  = 4'(PE_ID);
    localparam int         ROW_BASE = PE_ID - 5;
    localparam logic [4:0] LAST_IDX = 5'(OUTPUT_SIZE - 1);

    state_e      state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  rows_req_q, rows_req_d;
    logic        outstanding_q, outstanding_d;
    logic        req_valid_q, req_valid_d;
    logic [32:0] req_pkt_q, req_pkt_d;
    logic        row_done_q, row_done_d;
    logic        ts_done_q, ts_done_d;
    logic        pkt_drop_q, pkt_drop_d;

    pkt_t        pkt_s;
    logic        accept_s;
    logic        is_data_s;
    logic        load_first_s;
    logic        load_shadow_s;
    logic        shadow_full_s;
    logic        swap_s;
    logic        swap_bypass_s;
    logic        clear_s;
    logic        win_fire_s;
    logic        req_fire_s;
    logic        want_req_s;
    logic [24:0] next_row_s;

    assign pkt_s         = pkt_in;
    assign pkt_in_ready  = !shadow_full_s;
    assign accept_s      = pkt_in_valid && !shadow_full_s;
    assign is_data_s     = (pkt_s.dest == PE_ADDR) && (pkt_s.opcode == OP_PPE_INPUT);
    assign load_first_s  = accept_s && is_data_s && (state_q == WAIT_FIRST);
    // Row data outside WAIT_FIRST is only legal as the answer to our own request
    assign load_shadow_s = accept_s && is_data_s && outstanding_q &&
                           ((state_q == STREAM) || (state_q == STALL));
    assign win_valid     = (state_q == STREAM);
    assign win_fire_s    = win_valid && win_ready;
    assign req_fire_s    = req_valid_q && req_ready;
    assign next_row_s    = 25'(ROW_BASE + 1) + {20'd0, rows_req_q};

    ppe_row_dbuf u_dbuf (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_s),
        .load_active_i (load_first_s),
        .load_shadow_i (load_shadow_s),
        .swap_i        (swap_s),
        .swap_bypass_i (swap_bypass_s),
        .data_i        (pkt_s.data),
        .col_i         (col_q),
        .shadow_full_o (shadow_full_s),
        .win_data_o    (win_data)
    );

    // Sequencing FSM: state, window position and row/timestep pulses
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        swap_s        = 1'b0;
        swap_bypass_s = 1'b0;
        clear_s       = 1'b0;
        row_done_d    = 1'b0;
        ts_done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_FIRST;
                    col_d   = 5'd0;
                    row_d   = 5'd0;
                    clear_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_FIRST: begin
                if (load_first_s) begin
                    state_d = STREAM;
                end else begin
                    state_d = WAIT_FIRST;
                end
            end
            STREAM: begin
                if (win_fire_s && (col_q == LAST_IDX)) begin
                    row_done_d = 1'b1;
                    if (row_q == LAST_IDX) begin
                        ts_done_d = 1'b1;
                        state_d   = IDLE;
                    end else if (shadow_full_s || load_shadow_s) begin
                        swap_s        = 1'b1;
                        swap_bypass_s = !shadow_full_s;
                        col_d         = 5'd0;
                        row_d         = row_q + 5'd1;
                    end else begin
                        state_d = STALL;
                    end
                end else if (win_fire_s) begin
                    col_d = col_q + 5'd1;
                end else begin
                    state_d = STREAM;
                end
            end
            STALL: begin
                if (shadow_full_s) begin
                    swap_s  = 1'b1;
                    col_d   = 5'd0;
                    row_d   = row_q + 5'd1;
                    state_d = STREAM;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Prefetch request generation and outstanding tracking
    always_comb begin
        want_req_s = (load_first_s || swap_s) && (rows_req_q < LAST_IDX) &&
                     !(outstanding_q && !load_shadow_s) && !req_valid_q;
        req_valid_d = req_valid_q;
        req_pkt_d   = req_pkt_q;
        if (req_fire_s) begin
            req_valid_d = 1'b0;
        end else if (want_req_s) begin
            req_valid_d = 1'b1;
            req_pkt_d   = {IMEM_ID, PE_ADDR, next_row_s};
        end else begin
            req_valid_d = req_valid_q;
        end
        if (req_fire_s) begin
            outstanding_d = 1'b1;
        end else if (load_shadow_s) begin
            outstanding_d = 1'b0;
        end else begin
            outstanding_d = outstanding_q;
        end
        if (clear_s) begin
            rows_req_d = 5'd0;
        end else if (req_fire_s) begin
            rows_req_d = rows_req_q + 5'd1;
        end else begin
            rows_req_d = rows_req_q;
        end
        pkt_drop_d = accept_s && !load_first_s && !load_shadow_s;
    end

    // All state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            col_q         <= 5'd0;
            row_q         <= 5'd0;
            rows_req_q    <= 5'd0;
            outstanding_q <= 1'b0;
            req_valid_q   <= 1'b0;
            req_pkt_q     <= 33'd0;
            row_done_q    <= 1'b0;
            ts_done_q     <= 1'b0;
            pkt_drop_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            rows_req_q    <= rows_req_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= req_valid_d;
            req_pkt_q     <= req_pkt_d;
            row_done_q    <= row_done_d;
            ts_done_q     <= ts_done_d;
            pkt_drop_q    <= pkt_drop_d;
        end
    end

    assign req_pkt   = req_pkt_q;
    assign req_valid = req_valid_q;
    assign win_col   = col_q;
    assign win_row   = row_q;
    assign row_done  = row_done_q;
    assign ts_done   = ts_done_q;
    assign pkt_drop  = pkt_drop_q;

endmodule
